// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch flush.
// Controls are squashed on flush or on a load-use bubble. Data and address
// fields keep capturing in those cases, so EX always sees the ID operands.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic [1:0]        id_aluop_i,
    input  logic              id_alusrc_i,
    input  logic              id_regwrite_i,
    input  logic              id_regdst_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_memtoreg_i,
    input  logic [1:0]        id_branch_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [5:0]        id_funct_i,
    input  logic              id_uses_rt_i,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic [1:0]        ex_branch_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [5:0]        ex_funct_o,
    output logic [REG_AW-1:0] ex_wr_addr_o,
    output logic              ex_valid_o,
    output logic              stall_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    logic hazard;

    // Load in EX whose destination is read by the ID instruction; $0 is never a dependency.
    assign hazard = ex_memread_o && (ex_rt_o != '0) &&
                    ((ex_rt_o == id_rs_i) || (id_uses_rt_i && (ex_rt_o == id_rt_i)));

    // A flush discards the dependent instruction anyway, so it must not stall the front end.
    assign stall_o = hazard & ~flush_i;

    // Control path: cleared on flush or bubble, frozen on hold, otherwise captured.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_aluop_o    <= '0;
            ex_alusrc_o   <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_branch_o   <= '0;
            ex_valid_o    <= 1'b0;
        end else if (flush_i || (!hold_i && hazard)) begin
            ex_aluop_o    <= '0;
            ex_alusrc_o   <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_branch_o   <= '0;
            ex_valid_o    <= 1'b0;
        end else if (!hold_i) begin
            ex_aluop_o    <= id_aluop_i;
            ex_alusrc_o   <= id_alusrc_i;
            ex_regwrite_o <= id_regwrite_i;
            ex_memread_o  <= id_memread_i;
            ex_memwrite_o <= id_memwrite_i;
            ex_memtoreg_o <= id_memtoreg_i;
            ex_branch_o   <= id_branch_i;
            ex_valid_o    <= 1'b1;
        end
    end

    // Data and address path: captured unless held; a flush overrides hold.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_pc4_o     <= '0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_funct_o   <= '0;
            ex_wr_addr_o <= '0;
        end else if (flush_i || !hold_i) begin
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_pc4_o     <= id_pc4_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_funct_o   <= id_funct_i;
            ex_wr_addr_o <= id_regdst_i ? id_rd_i : id_rt_i;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating event counters; flushes still count while the pipeline is held.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (flush_i && (flush_cnt_o != 32'hFFFF_FFFF))
                flush_cnt_o <= flush_cnt_o + 32'd1;
            if (!flush_i && !hold_i && hazard && (stall_cnt_o != 32'hFFFF_FFFF))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a reference model predicts every EX register and
// stall_o per cycle; predictions are queued at drive time and popped after the edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic [1:0]  aluop;
        logic        alusrc, regwrite, memread, memwrite, memtoreg;
        logic [1:0]  branch;
        logic        valid;
        logic [31:0] rs_data, rt_data, imm, pc4;
        logic [4:0]  rs, rt, wr;
        logic [5:0]  funct;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, flush, hold;
    logic [1:0]  id_aluop, id_branch;
    logic        id_alusrc, id_regwrite, id_regdst, id_memread, id_memwrite, id_memtoreg, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;

    logic [1:0]  ex_aluop, ex_branch;
    logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, stall;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_wr_addr;
    logic [5:0]  ex_funct;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    ex_t  m;
    ex_t  exp_q[$];
    logic last_stall;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold),
        .id_aluop_i(id_aluop), .id_alusrc_i(id_alusrc), .id_regwrite_i(id_regwrite),
        .id_regdst_i(id_regdst), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .id_memtoreg_i(id_memtoreg), .id_branch_i(id_branch),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_pc4_i(id_pc4),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_funct_i(id_funct),
        .id_uses_rt_i(id_uses_rt),
        .ex_aluop_o(ex_aluop), .ex_alusrc_o(ex_alusrc), .ex_regwrite_o(ex_regwrite),
        .ex_memread_o(ex_memread), .ex_memwrite_o(ex_memwrite), .ex_memtoreg_o(ex_memtoreg),
        .ex_branch_o(ex_branch), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
        .ex_imm_o(ex_imm), .ex_pc4_o(ex_pc4), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
        .ex_funct_o(ex_funct), .ex_wr_addr_o(ex_wr_addr), .ex_valid_o(ex_valid),
        .stall_o(stall)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_data();
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        id_pc4     = $urandom;
        id_funct   = 6'($urandom);
    endtask

    task automatic set_ctrl(input logic [1:0] aluop, input logic regdst, input logic alusrc,
                            input logic regwrite, input logic memread, input logic memwrite,
                            input logic memtoreg, input logic [1:0] branch,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic uses_rt);
        id_aluop = aluop; id_regdst = regdst; id_alusrc = alusrc; id_regwrite = regwrite;
        id_memread = memread; id_memwrite = memwrite; id_memtoreg = memtoreg;
        id_branch = branch; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt;
        rand_data();
    endtask

    // Expected EX contents after a capture; ctl=0 models a squashed (bubble) capture.
    function automatic ex_t capture(input logic ctl);
        ex_t c;
        c.rs_data = id_rs_data; c.rt_data = id_rt_data; c.imm = id_imm; c.pc4 = id_pc4;
        c.rs = id_rs; c.rt = id_rt; c.funct = id_funct;
        c.wr = id_regdst ? id_rd : id_rt;
        c.aluop    = ctl ? id_aluop    : 2'b00;
        c.alusrc   = ctl ? id_alusrc   : 1'b0;
        c.regwrite = ctl ? id_regwrite : 1'b0;
        c.memread  = ctl ? id_memread  : 1'b0;
        c.memwrite = ctl ? id_memwrite : 1'b0;
        c.memtoreg = ctl ? id_memtoreg : 1'b0;
        c.branch   = ctl ? id_branch   : 2'b00;
        c.valid    = ctl;
        return c;
    endfunction

    // One cycle: check stall_o, predict next EX state, clock, then compare.
    task automatic step();
        ex_t  n, e;
        logic hz;
        #1;
        hz = m.memread && (m.rt != 5'd0) && ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
        last_stall = stall;
        check_val("stall", 64'(stall), 64'(hz && !flush));
        if (!rst)        n = '0;
        else if (flush)  n = capture(1'b0);
        else if (hold)   n = m;
        else if (hz)     n = capture(1'b0);
        else             n = capture(1'b1);
`ifdef ID_EX_PERF_CNT_EN
        if (!rst) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
            if (!flush && !hold && hz && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        end
`endif
        exp_q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("aluop",    64'(ex_aluop),    64'(e.aluop));
        check_val("alusrc",   64'(ex_alusrc),   64'(e.alusrc));
        check_val("regwrite", 64'(ex_regwrite), 64'(e.regwrite));
        check_val("memread",  64'(ex_memread),  64'(e.memread));
        check_val("memwrite", 64'(ex_memwrite), 64'(e.memwrite));
        check_val("memtoreg", 64'(ex_memtoreg), 64'(e.memtoreg));
        check_val("branch",   64'(ex_branch),   64'(e.branch));
        check_val("valid",    64'(ex_valid),    64'(e.valid));
        check_val("rs_data",  64'(ex_rs_data),  64'(e.rs_data));
        check_val("rt_data",  64'(ex_rt_data),  64'(e.rt_data));
        check_val("imm",      64'(ex_imm),      64'(e.imm));
        check_val("pc4",      64'(ex_pc4),      64'(e.pc4));
        check_val("rs",       64'(ex_rs),       64'(e.rs));
        check_val("rt",       64'(ex_rt),       64'(e.rt));
        check_val("wr_addr",  64'(ex_wr_addr),  64'(e.wr));
        check_val("funct",    64'(ex_funct),    64'(e.funct));
`ifdef ID_EX_PERF_CNT_EN
        check_val("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        check_val("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`endif
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        set_ctrl(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, rs, rt, 5'd0, 1'b0);
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_ctrl(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, rs, rt, rd, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            set_ctrl(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 1'($urandom));
            step();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        rtype(5'd1, 5'd2, 5'd3);
        m = '0;
`ifdef ID_EX_PERF_CNT_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        @(posedge clk);
        #1;

        // Reset with random inputs.
        do_reset(2);
        check_val("rst_valid", 64'(ex_valid), 64'd0);
        check_val("rst_stall", 64'(stall), 64'd0);

        // Normal R-type capture.
        rtype(5'd8, 5'd9, 5'd10);
        step();
        check_val("rtype_wr", 64'(ex_wr_addr), 64'd10);
        check_val("rtype_aluop", 64'(ex_aluop), 64'd2);
        check_val("rtype_valid", 64'(ex_valid), 64'd1);

        // Load-use: one stall, one bubble, then the dependent instruction.
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd4, 5'd5);
        step();
        check_val("lu_stall", 64'(last_stall), 64'd1);
        check_val("lu_bubble_rw", 64'(ex_regwrite), 64'd0);
        check_val("lu_bubble_valid", 64'(ex_valid), 64'd0);
        step();
        check_val("lu_stall_once", 64'(last_stall), 64'd0);
        check_val("lu_dep_valid", 64'(ex_valid), 64'd1);

        // Load into $0 never stalls.
        lw(5'd8, 5'd0);
        step();
        rtype(5'd0, 5'd0, 5'd6);
        step();
        check_val("zero_nostall", 64'(last_stall), 64'd0);

        // rt match ignored when ID does not read rt.
        lw(5'd8, 5'd9);
        step();
        set_ctrl(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd3, 5'd9, 5'd0, 1'b0);
        step();
        check_val("addi_nostall", 64'(last_stall), 64'd0);

        // Flush beats hazard.
        do_reset(1);
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd9, 5'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_stall", 64'(last_stall), 64'd0);
        check_val("flush_valid", 64'(ex_valid), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        check_val("flush_cnt1", 64'(flush_cnt), 64'd1);
        check_val("stall_cnt0", 64'(stall_cnt), 64'd0);
`endif

        // Hold with changing inputs, then release.
        rtype(5'd11, 5'd12, 5'd13);
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rtype(5'($urandom), 5'($urandom), 5'($urandom));
            step();
            check_val("hold_wr", 64'(ex_wr_addr), 64'd13);
        end
        hold = 1'b0;
        rtype(5'd14, 5'd15, 5'd16);
        step();
        check_val("hold_release_wr", 64'(ex_wr_addr), 64'd16);

        // Hold during hazard: stall persists, bubble only after release.
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd1, 5'd2);
        hold = 1'b1;
        step();
        step();
        check_val("hold_hz_stall", 64'(last_stall), 64'd1);
        hold = 1'b0;
        step();
        check_val("hold_hz_bubble", 64'(ex_valid), 64'd0);
        step();

        // Reset in the middle of a stall.
        lw(5'd8, 5'd9);
        step();
        rtype(5'd9, 5'd1, 5'd2);
        rst = 1'b0;
        step();
        check_val("rst_mid_stall", 64'(last_stall), 64'd1);
        rst = 1'b1;
        step();
        check_val("rst_after_stall", 64'(last_stall), 64'd0);

        // Random traffic over a small register set to provoke dependencies.
        for (int i = 0; i < 400; i++) begin
            set_ctrl(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 2'($urandom),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom));
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 39) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipelined MIPS core; sits directly downstream of the instruction decoder.
- Captures decoder control outputs, register-file operands, immediate and register addresses on every clock edge.
- Contains the load-use hazard detector, which inserts one bubble per load-use dependency.
- Applies flushes from the branch-resolution stage.

Parameters:
- DATA_W, 32, operand, immediate and PC width.
- REG_AW, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-low.
- flush_i  in  1  branch taken in MEM; squash the instruction being captured.
- hold_i  in  1  global freeze; retain all register contents.
- id_aluop_i  in  2  decoder ALUOp (10 R-type, 01 branch, 00 add).
- id_alusrc_i, id_regwrite_i, id_regdst_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1 each  decoder controls.
- id_branch_i  in  2  01 BEQ, 10 BNE, 00 none.
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data.
- id_imm_i  in  DATA_W  sign-extended immediate.
- id_pc4_i  in  DATA_W  PC+4 of the ID instruction.
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW  instruction register fields.
- id_funct_i  in  6  funct field.
- id_uses_rt_i  in  1  ID instruction reads rt as a source (R-type, BEQ, BNE, SW).
- ex_* outputs  out  same widths as the id_* inputs  registered copies: aluop, alusrc, regwrite, memread, memwrite, memtoreg, branch, rs_data, rt_data, imm, pc4, rs, rt, funct.
- ex_wr_addr_o  out  REG_AW  destination register: rd if regdst, else rt; resolved at capture.
- ex_valid_o  out  1  0 when EX holds a bubble.
- stall_o  out  1  combinational; freezes PC and IF/ID.

Behaviour:
- Reset (rst_i=0 at an edge): all ex_* outputs, ex_wr_addr_o and ex_valid_o are cleared to 0. Reset has priority over every other input.
- Hazard is combinational: ex_memread_o & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (id_uses_rt_i & ex_rt_o == id_rt_i)).
- stall_o = hazard & ~flush_i.
- Update priority at each rising edge: reset > flush > hold > hazard > load.
  - flush_i=1: all control outputs 0, ex_valid_o=0; data and address fields capture the inputs normally.
  - hold_i=1 (no flush): every register retains its value.
  - hazard=1: bubble. Control outputs 0, ex_valid_o=0, data fields captured. The next cycle's ex_memread_o is 0, so each load-use stalls exactly one cycle.
  - otherwise: capture all inputs, set ex_valid_o=1, ex_wr_addr_o = id_regdst_i ? id_rd_i : id_rt_i.
- Latency: one cycle from id_* inputs to ex_* outputs.
- Register $0 destination never triggers a hazard.
- Hold asserted while hazard=1: stall_o stays 1 and no bubble is inserted until hold_i falls.
- Flush and hazard in the same cycle: flush wins, stall_o=0, a bubble is captured.
- Reset asserted mid-stall: stall_o falls in the cycle after reset, because ex_memread_o is 0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Enabled, adds two outputs:
  - stall_cnt_o[31:0]: increments on each edge where a hazard bubble is inserted.
  - flush_cnt_o[31:0]: increments on each edge where flush_i=1 and rst_i=1.
  - Both counters saturate at 32'hFFFFFFFF, clear on reset, and do not count while hold_i=1, except that flushes are still counted during hold.
- Disabled: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: rst_i=0 for 2 cycles with random inputs -> all ex_* = 0, ex_valid_o=0, stall_o=0.
- Normal capture: R-type add with rs=8, rt=9, rd=10, regdst=1, regwrite=1, aluop=10 -> next cycle ex_wr_addr_o=10, ex_aluop_o=10, ex_valid_o=1.
- Load-use: LW with rt=9 captured; next ID instruction has rs=9 -> stall_o=1 for exactly one cycle, a bubble is captured (ex_regwrite_o=0, ex_valid_o=0), and the dependent instruction is then captured with ex_valid_o=1.
- Load-use filters:
  - LW rt=0 followed by a reader of $0 -> stall_o stays 0.
  - LW rt=9 followed by ADDI reading rt=9 with id_uses_rt_i=0 -> no stall.
- Flush priority: hazard condition and flush_i=1 in the same cycle -> stall_o=0, bubble captured. With ID_EX_PERF_CNT_EN: flush_cnt_o goes 0 -> 1 and stall_cnt_o stays 0.
- Hold: hold_i=1 for 3 cycles with changing inputs -> ex_* outputs unchanged. Then hold_i=0 -> the current inputs are captured on the next edge.
